// File: rtl/mem_copy_engine.sv
// Word-copy bus initiator: reads a source word, writes it to the destination, two cycles per word.
// Optional running checksum of all words read is enabled with MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, dst_q, last_a_q;
  logic [LEN_W-1:0]    rem_q;
  logic [31:0]         data_q;

  // Byte-offset bits of the programmed addresses are dropped by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len == '0) ? StFin : StRd;
        end
      end
      StRd:   state_d = StWr;
      StWr:   state_d = (rem_q == LEN_W'(1)) ? StFin : StRd;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      last_a_q <= '0;
      rem_q    <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q <= {src_addr[ADDR_W-1:2], 2'b00};
            dst_q <= {dst_addr[ADDR_W-1:2], 2'b00};
            rem_q <= len;
          end
        end
        StRd: begin
          data_q   <= mem_rd;
          last_a_q <= src_q;
        end
        StWr: begin
          src_q    <= src_q + ADDR_W'(4);
          dst_q    <= dst_q + ADDR_W'(4);
          rem_q    <= rem_q - LEN_W'(1);
          last_a_q <= dst_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only from state and registers; mem_a holds the last address outside RD/WR.
  always_comb begin
    mem_a  = last_a_q;
    mem_we = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      StRd: begin
        mem_a = src_q;
        busy  = 1'b1;
      end
      StWr: begin
        mem_a  = dst_q;
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  assign mem_wd = data_q;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q == StIdle && start) begin
      sum_q <= '0;
    end else if (state_q == StRd) begin
      sum_q <= sum_q + mem_rd;
    end
  end

  assign checksum = sum_q;
`else
  // Default build carries no checksum state.
`endif

endmodule
